// File: rtl/na_ep_wb_ingress.sv
// Wishbone slave that buffers NoC flits and hands only complete packets to the NI injection port.
// WB response 1 cycle after request; packet visible one cycle after its last ack; out_ready=0 stalls, full FIFO errs.
module na_ep_wb_ingress #(
    parameter int NOC_FLIT_WIDTH  = 32,
    parameter int DEPTH           = 16,
    parameter int MAX_NOC_PKT_LEN = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [3:0]                wb_adr_i,
    input  logic [NOC_FLIT_WIDTH-1:0] wb_dat_i,
    output logic [NOC_FLIT_WIDTH-1:0] wb_dat_o,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    output logic [NOC_FLIT_WIDTH-1:0] out_flit,
    output logic                      out_valid,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    pkt_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(MAX_NOC_PKT_LEN + 1) + 1;
    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic [LW-1:0] MAX_P    = LW'(MAX_NOC_PKT_LEN);
    localparam logic [3:0]    ADR_DATA = 4'h0;
    localparam logic [3:0]    ADR_LAST = 4'h4;
    localparam logic [3:0]    ADR_STAT = 4'h8;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DROP} state_t;

    state_t                    state_q, state_d;
    logic [LW-1:0]             len_q, len_d;
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]             com_ptr_q, com_ptr_d;
    logic [PW-1:0]             cptr_q, cptr_d;
    logic                      commit_q, commit_d;
    logic [PW-1:0]             pkt_cnt_q, pkt_cnt_d;
    logic                      ack_q, ack_d;
    logic                      err_q, err_d;
    logic [NOC_FLIT_WIDTH-1:0] dat_q, dat_d;
    logic [NOC_FLIT_WIDTH:0]   mem_q [DEPTH];

    logic                      req, is_data, is_last, is_stat, mem_we;
    logic                      pop, pop_last;
    logic [PW-1:0]             free;
    logic [LW-1:0]             new_len;
    logic [NOC_FLIT_WIDTH-1:0] status;
    logic [NOC_FLIT_WIDTH:0]   rd_ent;

    always_comb begin
        req     = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
        is_data = wb_we_i & (wb_adr_i == ADR_DATA);
        is_last = wb_we_i & (wb_adr_i == ADR_LAST);
        is_stat = ~wb_we_i & (wb_adr_i == ADR_STAT);
        free    = DEPTH_P - (wr_ptr_q - rd_ptr_q);
        new_len = (state_q == S_IDLE) ? LW'(1) : len_q + LW'(1);
        status         = '0;
        status[15:0]   = 16'(free);
        status[31:16]  = 16'(pkt_cnt_q);
    end

    // Write-side FSM; commit is registered so the packet count lags the last ack by one cycle.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wr_ptr_d = wr_ptr_q;
        cptr_d   = cptr_q;
        commit_d = 1'b0;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        dat_d    = '0;
        mem_we   = 1'b0;
        if (req) begin
            if (is_stat) begin
                ack_d = 1'b1;
                dat_d = status;
            end else if (is_data || is_last) begin
                if (state_q == S_DROP) begin
                    ack_d = 1'b1;
                    len_d = '0;
                    if (is_last) state_d = S_IDLE;
                end else if (new_len > MAX_P) begin
                    wr_ptr_d = com_ptr_q;
                    err_d    = 1'b1;
                    len_d    = '0;
                    state_d  = S_DROP;
                end else if (free == '0) begin
                    wr_ptr_d = com_ptr_q;
                    err_d    = 1'b1;
                    len_d    = '0;
                    state_d  = is_last ? S_IDLE : S_DROP;
                end else begin
                    mem_we   = 1'b1;
                    ack_d    = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    if (is_last) begin
                        commit_d = 1'b1;
                        cptr_d   = wr_ptr_q + PW'(1);
                        len_d    = '0;
                        state_d  = S_IDLE;
                    end else begin
                        len_d    = new_len;
                        state_d  = S_FILL;
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    assign rd_ent    = mem_q[rd_ptr_q[AW-1:0]];
    assign out_valid = (pkt_cnt_q != '0);
    assign out_flit  = out_valid ? rd_ent[NOC_FLIT_WIDTH-1:0] : '0;
    assign out_last  = out_valid & rd_ent[NOC_FLIT_WIDTH];
    assign pkt_count = pkt_cnt_q;
    assign wb_ack_o  = ack_q;
    assign wb_err_o  = err_q;
    assign wb_dat_o  = dat_q;

    always_comb begin
        pop       = out_valid & out_ready;
        pop_last  = pop & rd_ent[NOC_FLIT_WIDTH];
        rd_ptr_d  = rd_ptr_q + (pop ? PW'(1) : PW'(0));
        com_ptr_d = commit_q ? cptr_q : com_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        case ({commit_q, pop_last})
            2'b10:   pkt_cnt_d = pkt_cnt_q + PW'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - PW'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= {is_last, wb_dat_i};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            com_ptr_q <= '0;
            cptr_q    <= '0;
            commit_q  <= 1'b0;
            pkt_cnt_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            com_ptr_q <= com_ptr_d;
            cptr_q    <= cptr_d;
            commit_q  <= commit_d;
            pkt_cnt_q <= pkt_cnt_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
        end
    end

endmodule

// File: tb/tb_na_ep_wb_ingress.sv
// Directed and randomised bench for na_ep_wb_ingress against a queue-based packet model.
module tb_na_ep_wb_ingress;

    localparam int NFW    = 32;
    localparam int DEPTH  = 16;
    localparam int MAXL   = 10;
    localparam int K_DATA = 0;
    localparam int K_LAST = 1;
    localparam int K_STAT = 2;
    localparam int K_RD0  = 3;
    localparam int K_RDC  = 4;
    localparam int K_WR8  = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [3:0]     wb_adr_i = '0;
    logic [NFW-1:0] wb_dat_i = '0;
    logic [NFW-1:0] wb_dat_o, out_flit;
    logic           wb_ack_o, wb_err_o, out_valid, out_last;
    logic           out_ready = 1'b0;
    logic [4:0]     pkt_count;

    int n_vec = 0;
    int n_bad = 0;

    logic [NFW:0] exp_q[$];
    logic [NFW:0] cur_q[$];
    bit           dropping = 1'b0;
    bit           rdy_rand = 1'b0;

    na_ep_wb_ingress #(.NOC_FLIT_WIDTH(NFW), .DEPTH(DEPTH), .MAX_NOC_PKT_LEN(MAXL)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .out_flit(out_flit), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: committed flits awaiting output plus the packet being assembled.
    function automatic int m_free();
        return DEPTH - exp_q.size() - cur_q.size();
    endfunction

    function automatic int m_pkts();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i][NFW]) n++;
        return n;
    endfunction

    function automatic bit m_push(input bit last, input logic [NFW-1:0] d);
        if (dropping) begin
            if (last) dropping = 1'b0;
            return 1'b0;
        end
        if (cur_q.size() + 1 > MAXL) begin
            cur_q.delete();
            dropping = 1'b1;
            return 1'b1;
        end
        if (m_free() == 0) begin
            cur_q.delete();
            dropping = !last;
            return 1'b1;
        end
        cur_q.push_back({last, d});
        if (last) begin
            foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
            cur_q.delete();
        end
        return 1'b0;
    endfunction

    function automatic void m_reset();
        exp_q.delete();
        cur_q.delete();
        dropping = 1'b0;
    endfunction

    // One WB transfer; the model is consulted at drive time so it sees the same FIFO state the DUT samples.
    task automatic wb_access(input int kind, input logic [NFW-1:0] d);
        bit             exp_err;
        bit             chk_dat;
        logic [NFW-1:0] exp_dat;
        chk_dat = 1'b0;
        exp_dat = '0;
        @(posedge clk); #1;
        check("resp_pulse", {wb_ack_o, wb_err_o}, 2'b00);
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_dat_i = d;
        case (kind)
            K_DATA: begin wb_we_i = 1'b1; wb_adr_i = 4'h0; exp_err = m_push(1'b0, d); end
            K_LAST: begin wb_we_i = 1'b1; wb_adr_i = 4'h4; exp_err = m_push(1'b1, d); end
            K_STAT: begin
                wb_we_i = 1'b0; wb_adr_i = 4'h8; exp_err = 1'b0; chk_dat = 1'b1;
                exp_dat = {16'(m_pkts()), 16'(m_free())};
            end
            K_RD0:  begin wb_we_i = 1'b0; wb_adr_i = 4'h0; exp_err = 1'b1; end
            K_RDC:  begin wb_we_i = 1'b0; wb_adr_i = 4'hC; exp_err = 1'b1; end
            default: begin wb_we_i = 1'b1; wb_adr_i = 4'h8; exp_err = 1'b1; end
        endcase
        @(posedge clk); #1;
        check($sformatf("resp_k%0d", kind), {wb_ack_o, wb_err_o}, exp_err ? 2'b01 : 2'b10);
        if (chk_dat) check("status", wb_dat_o, exp_dat);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain_left", exp_q.size(), 0);
        check("drain_valid", out_valid, 1'b0);
    endtask

    // Output scoreboard: a flit seen with valid&ready at the falling edge pops at the next rising edge.
    always @(negedge clk) begin : mon
        logic [NFW:0] e;
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_pop", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("out_flit", {out_last, out_flit}, e);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {wb_ack_o, wb_err_o}, 2'b00);
        check("rst_dat", wb_dat_o, 0);
        check("rst_out", {out_valid, out_last, out_flit}, 0);
        check("rst_pkt", pkt_count, 0);
        rst = 1'b1;

        // Basic 3-flit packet with immediate drain.
        out_ready = 1'b1;
        wb_access(K_DATA, 32'hA0);
        wb_access(K_DATA, 32'hA1);
        wb_access(K_LAST, 32'hA2);
        check("t1_valid_at_ack", out_valid, 1'b0);
        @(posedge clk); #1;
        check("t1_valid_rise", out_valid, 1'b1);
        check("t1_pkt1", pkt_count, 1);
        repeat (5) @(posedge clk);
        #1;
        check("t1_pkt0", pkt_count, 0);
        check("t1_all_seen", exp_q.size(), 0);

        // Over-long packet rolled back, then a clean packet.
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) wb_access(K_DATA, 32'hB00 + i);
        wb_access(K_LAST, 32'hB0A);
        check("t2_no_valid", {out_valid, out_flit}, 0);
        wb_access(K_STAT, 0);
        wb_access(K_LAST, 32'hB0B);
        wb_access(K_DATA, 32'hC0);
        wb_access(K_DATA, 32'hC1);
        wb_access(K_LAST, 32'hC2);
        drain();

        // Fill to capacity with two 8-flit packets, overflow into DROP.
        out_ready = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 7; i++) wb_access(K_DATA, 32'hD00 + p * 16 + i);
            wb_access(K_LAST, 32'hD07 + p * 16);
        end
        wb_access(K_DATA, 32'hDEAD);
        wb_access(K_STAT, 0);
        drain();
        wb_access(K_LAST, 32'hDEAF);
        wb_access(K_STAT, 0);

        // Commit coincides with popping the previous packet's last flit.
        out_ready = 1'b0;
        wb_access(K_LAST, 32'hE0);
        wb_access(K_LAST, 32'hE1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("t4_pkt_hold", pkt_count, 1);
        check("t4_valid_hold", out_valid, 1'b1);
        drain();

        // Illegal accesses mid-packet change nothing; back-to-back spacing.
        out_ready = 1'b0;
        wb_access(K_DATA, 32'hF0);
        wb_access(K_STAT, 0);
        wb_access(K_RD0, 0);
        wb_access(K_RDC, 0);
        wb_access(K_WR8, 32'hFFFF);
        wb_access(K_STAT, 0);
        wb_access(K_LAST, 32'hF1);
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 4'h8;
        @(posedge clk); #1;
        check("b2b_first", {wb_ack_o, wb_err_o}, 2'b10);
        @(posedge clk); #1;
        check("b2b_gap", {wb_ack_o, wb_err_o}, 2'b00);
        @(posedge clk); #1;
        check("b2b_second", {wb_ack_o, wb_err_o}, 2'b10);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        drain();

        // Reset mid-packet with a committed packet held.
        out_ready = 1'b0;
        wb_access(K_LAST, 32'h60);
        wb_access(K_DATA, 32'h61);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("t6_out_zero", {out_valid, out_last, out_flit}, 0);
        check("t6_pkt_zero", pkt_count, 0);
        m_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        wb_access(K_STAT, 0);
        wb_access(K_LAST, 32'h62);
        drain();

        // Randomised traffic with random NI backpressure.
        rdy_rand = 1'b1;
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 62)      wb_access(K_DATA, $urandom);
            else if (r < 82) wb_access(K_LAST, $urandom);
            else if (r < 94) wb_access(K_STAT, 0);
            else             wb_access($urandom_range(K_RD0, K_WR8), $urandom);
        end
        rdy_rand = 1'b0;
        drain();
        wb_access(K_STAT, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
